// File: rtl/dzrbuf_pkg.sv
// Shared types and RBUF field positions for the DZ11 receive path.
package dzrbuf_pkg;

  localparam int DZ_NUM_LINES = 8;

  localparam int RB_DVAL = 15;
  localparam int RB_OERR = 14;
  localparam int RB_FERR = 13;
  localparam int RB_PERR = 12;
  localparam int RB_LINE = 8;
  localparam int RB_CHAR = 0;

  typedef struct packed {
    logic       ovf;
    logic       ferr;
    logic       perr;
    logic [2:0] line;
    logic [7:0] data;
  } siloEntry_t;

  function automatic logic [15:0] fmtRbuf(input siloEntry_t e);
    logic [15:0] r;
    r                    = '0;
    r[RB_DVAL]           = 1'b1;
    r[RB_OERR]           = e.ovf;
    r[RB_FERR]           = e.ferr;
    r[RB_PERR]           = e.perr;
    r[RB_LINE+:3]        = e.line;
    r[RB_CHAR+:8]        = e.data;
    return r;
  endfunction

endpackage

// File: rtl/dz_silo.sv
// Receive silo: synchronous FIFO with a registered head entry so RBUF
// is a flop output and never a RAM read path.
module dz_silo
  import dzrbuf_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  siloEntry_t wrData,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count,
  output siloEntry_t headData,
  output logic       headVld
);

  siloEntry_t      mem [DEPTH];
  logic [AW-1:0]   head, tail, headNext;
  logic [AW:0]     cntAfterPop;
  logic            doPush, doPop;

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign doPop       = pop & ~empty;
  assign doPush      = push & (~full | doPop);
  assign headNext    = head + AW'(doPop);
  assign cntAfterPop = count - (AW+1)'(doPop);

  always_ff @(posedge clk)
    if (doPush && !clr) mem[tail] <= wrData;

  // A push landing in an otherwise-empty silo becomes the head directly,
  // since mem[] is not yet written at this edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      headVld  <= 1'b0;
      headData <= '0;
    end else begin
      head    <= headNext;
      tail    <= tail + AW'(doPush);
      count   <= cntAfterPop + (AW+1)'(doPush);
      headVld <= (cntAfterPop != '0) | doPush;
      if (doPush && cntAfterPop == '0) headData <= wrData;
      else if (cntAfterPop != '0)      headData <= mem[headNext];
      else                             headData <= '0;
    end
  end

endmodule

// File: rtl/dz_rbuf.sv
// DZ11 receive path: line scanner, overrun tracking and RBUF/RDONE/SA.
// Optional silo alarm is built when DZ_SILO_ALARM_EN is defined.
module dz_rbuf
  import dzrbuf_pkg::*;
#(
  parameter int SILO_DEPTH  = 64,
  parameter int ALARM_LEVEL = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devRESET,
  input  logic        csrCLR,
  input  logic        csrMSE,
  input  logic [7:0]  lprRXENA,
  input  logic [7:0]  uartRXFULL,
  input  logic [63:0] uartRXDATA,
  input  logic [7:0]  uartRXFERR,
  input  logic [7:0]  uartRXPERR,
  output logic [7:0]  uartRXACK,
  input  logic        rbufREAD,
  output logic [15:0] regRBUF,
  output logic        csrRDONE,
  output logic        csrSA
);

  localparam int AW = $clog2(SILO_DEPTH);

  logic        clr;
  logic [2:0]  scanLine;
  logic        take, wantPush, doPop, siloPush, drop, ovfFlag;
  logic        full, empty, headVld;
  logic [AW:0] count;
  siloEntry_t  wrEntry, headEntry;

  assign clr      = rst | devRESET | csrCLR;
  assign take     = ~clr & csrMSE & uartRXFULL[scanLine];
  assign wantPush = take & lprRXENA[scanLine];
  assign doPop    = rbufREAD & ~empty;
  assign siloPush = wantPush & (~full | doPop);
  assign drop     = wantPush & full & ~doPop;

  always_comb begin
    uartRXACK           = '0;
    uartRXACK[scanLine] = take;
  end

  always_comb begin
    wrEntry.ovf  = ovfFlag;
    wrEntry.ferr = uartRXFERR[scanLine];
    wrEntry.perr = uartRXPERR[scanLine];
    wrEntry.line = scanLine;
    wrEntry.data = uartRXDATA[{scanLine, 3'b000} +: 8];
  end

  // Overrun is sticky until it has been reported in a pushed entry.
  always_ff @(posedge clk) begin
    if (clr) begin
      scanLine <= '0;
      ovfFlag  <= 1'b0;
    end else begin
      if (csrMSE)        scanLine <= scanLine + 3'd1;
      if (drop)          ovfFlag  <= 1'b1;
      else if (siloPush) ovfFlag  <= 1'b0;
    end
  end

  dz_silo #(.DEPTH(SILO_DEPTH)) uSilo (
    .clk      (clk),
    .clr      (clr),
    .push     (siloPush),
    .pop      (doPop),
    .wrData   (wrEntry),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .headData (headEntry),
    .headVld  (headVld)
  );

  assign regRBUF  = headVld ? fmtRbuf(headEntry) : 16'h0000;
  assign csrRDONE = (count != '0);

`ifdef DZ_SILO_ALARM_EN
  localparam int ACW = $clog2(ALARM_LEVEL + 1);
  logic [ACW-1:0] alarmCnt;

  // Any RBUF read restarts the count; a push in the same cycle counts as one.
  always_ff @(posedge clk) begin
    if (clr)
      alarmCnt <= '0;
    else if (rbufREAD)
      alarmCnt <= ACW'(siloPush);
    else if (siloPush && alarmCnt != ACW'(ALARM_LEVEL))
      alarmCnt <= alarmCnt + 1'b1;
  end

  assign csrSA = (alarmCnt == ACW'(ALARM_LEVEL));
`else
  assign csrSA = 1'b0;
`endif

endmodule
